// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply/divide unit for the execute stage.
//
// A one-cycle start pulse on ctrl_MULT or ctrl_DIV captures both operands.
// busy stays high until the edge that raises data_resultRDY. data_result and
// data_exception are registered and change only on the edge entering DONE.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   ctrl_MULT, ctrl_DIV start pulses (MULT wins when both are high)
//   data_operandA/B     signed operands (multiplicand/dividend, multiplier/divisor)
//   data_result         low WIDTH bits of the product, or the quotient
//   data_exception      overflow or divide-by-zero, valid with data_resultRDY
//   data_resultRDY      one-cycle completion pulse
//   busy                operation in flight
//
// Build option MULTDIV_BOOTH_EN: multiply uses radix-4 modified Booth
// (WIDTH/2 iterations). Otherwise radix-2 shift-add on magnitudes.
// Divide behaves identically in both builds.

module multdiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef MULTDIV_BOOTH_EN
    localparam logic [CntW-1:0] MulLast = CntW'(WIDTH / 2);
`else
    localparam logic [CntW-1:0] MulLast = CntW'(WIDTH);
`endif
    localparam logic [CntW-1:0] DivLast = CntW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;     // mul: product/multiplier; div: {remainder, quotient}
    logic [WIDTH-1:0]   opnd_q;    // magnitude of multiplicand (radix-2) or divisor
    logic               neg_q;     // result sign = signA ^ signB
    logic               dz_q;      // divisor was zero at capture
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;
`ifdef MULTDIV_BOOTH_EN
    logic [2*WIDTH-1:0] mcand_q;   // sign-extended multiplicand, shifted 2 per step
    logic [WIDTH:0]     mplr_q;    // {multiplier, 0} scanned 3 bits at a time
    logic [2*WIDTH-1:0] booth_pp;
`else
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
`endif

    logic               start;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH:0]     mul_upper;
    logic               mul_ovf;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_res;
    logic               div_ovf;

    always_comb begin
        start = ctrl_MULT | ctrl_DIV;
        mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_BOOTH_EN
        booth_pp = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: booth_pp = mcand_q;
            3'b011:         booth_pp = {mcand_q[2*WIDTH-2:0], 1'b0};
            3'b100:         booth_pp = -{mcand_q[2*WIDTH-2:0], 1'b0};
            3'b101, 3'b110: booth_pp = -mcand_q;
            default:        booth_pp = '0;
        endcase
        mul_prod = acc_q;
`else
        // Add multiplicand into the upper half when the multiplier LSB is set,
        // keeping the carry, then shift the whole accumulator right by one.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        mul_prod = neg_q ? -acc_q : acc_q;
`endif
        // Overflow when the product is not the sign extension of its low half.
        mul_upper = mul_prod[2*WIDTH-1:WIDTH-1];
        mul_ovf   = ~((&mul_upper) | (~|mul_upper));

        // Restoring step: shift in next dividend bit, subtract divisor if it fits.
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ok    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = {(div_ok ? div_rem : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ok};
        div_res   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // Only MIN_INT / -1 yields a positive quotient with the top bit set.
        div_ovf   = ~neg_q & acc_q[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
            mcand_q  <= '0;
            mplr_q   <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                // A start in any state aborts whatever is in flight.
                cnt_q  <= '0;
                busy_q <= 1'b1;
                neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                if (ctrl_MULT) begin
                    state_q <= StMul;
`ifdef MULTDIV_BOOTH_EN
                    acc_q   <= '0;
                    mcand_q <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                    mplr_q  <= {data_operandB, 1'b0};
`else
                    opnd_q  <= mag_a;
                    acc_q   <= {{WIDTH{1'b0}}, mag_b};
`endif
                end else begin
                    state_q <= StDiv;
                    opnd_q  <= mag_b;
                    acc_q   <= {{WIDTH{1'b0}}, mag_a};
                    dz_q    <= (data_operandB == '0);
                end
            end else begin
                case (state_q)
                    StMul: begin
                        if (cnt_q == MulLast) begin
                            state_q  <= StDone;
                            result_q <= mul_prod[WIDTH-1:0];
                            exc_q    <= mul_ovf;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
`ifdef MULTDIV_BOOTH_EN
                            acc_q   <= acc_q + booth_pp;
                            mcand_q <= {mcand_q[2*WIDTH-3:0], 2'b00};
                            mplr_q  <= {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
`else
                            acc_q <= mul_next;
`endif
                        end
                    end
                    StDiv: begin
                        if (dz_q) begin
                            state_q  <= StDone;
                            result_q <= '0;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end else if (cnt_q == DivLast) begin
                            state_q  <= StDone;
                            result_q <= div_res;
                            exc_q    <= div_ovf;
                            rdy_q    <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            acc_q <= div_next;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: stimulus pushes expected completions,
// a monitor pops and checks on every data_resultRDY pulse.

module tb_multdiv_iter;

    localparam int W = 32;
`ifdef MULTDIV_BOOTH_EN
    localparam int MulLat = W / 2 + 1;
`else
    localparam int MulLat = W + 1;
`endif
    localparam int DivLat = W + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ctrl_MULT = 1'b0;
    logic          ctrl_DIV = 1'b0;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          busy;

    multdiv_iter #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          edge_no;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: sample #1 after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_rdy: got RDY at edge %0d, expected none", edge_cnt);
                end else begin
                    e = sb.pop_front();
                    check({e.nm, "_result"}, data_result, e.res);
                    check({e.nm, "_exc"}, {31'b0, data_exception}, {31'b0, e.exc});
                    check({e.nm, "_rdy_edge"}, edge_cnt, e.edge_no);
                    check({e.nm, "_busy_low"}, {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                            input logic [31:0] b, output int e);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        e             = edge_cnt;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic push(input string nm, input logic [31:0] r, input logic x, input int ed);
        exp_t e;
        e.nm      = nm;
        e.res     = r;
        e.exc     = x;
        e.edge_no = ed;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clock);
            #2;
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input string nm, input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic x,
                          input int lat);
        int e;
        start_op(m, d, a, b, e);
        check({nm, "_busy_high"}, {31'b0, busy}, 32'd1);
        push(nm, r, x, e + lat);
        wait_drain(nm);
    endtask

    initial begin
        int e;
        #3000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        // 1: reset
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'b0, data_exception}, 32'd0);
        check("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_result", data_result, 32'd0);

        // 2-4: directed operations
        run_op("mul_m7x6", 1'b1, 1'b0, -32'sd7, 32'd6, 32'hFFFF_FFD6, 1'b0, MulLat);
        run_op("div_m17d5", 1'b0, 1'b1, -32'sd17, 32'd5, 32'hFFFF_FFFD, 1'b0, DivLat);
        run_op("div_9d0", 1'b0, 1'b1, 32'd9, 32'd0, 32'd0, 1'b1, 1);
        run_op("mul_ovf16", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, MulLat);
        run_op("mul_ovf31", 1'b1, 1'b0, 32'h4000_0000, 32'd2, 32'h8000_0000, 1'b1, MulLat);
        run_op("div_minm1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1,
               DivLat);

        // 5: restart aborts a multiply at edge 10
        start_op(1'b1, 1'b0, 32'd3, 32'd4, e);
        repeat (9) @(posedge clock);
        #1;
        check("abort_busy", {31'b0, busy}, 32'd1);
        check("abort_hold_result", data_result, 32'h8000_0000);
        check("abort_hold_exc", {31'b0, data_exception}, 32'd1);
        start_op(1'b0, 1'b1, 32'd100, 32'd7, e);
        push("div_100d7", 32'd14, 1'b0, e + DivLat);
        wait_drain("div_100d7");

        // Both starts high behaves as multiply; issued from DONE (back-to-back).
        run_op("both_hi", 1'b1, 1'b1, 32'd3, 32'd4, 32'd12, 1'b0, MulLat);
        run_op("mul_neg_neg", 1'b1, 1'b0, -32'sd9, -32'sd11, 32'd99, 1'b0, MulLat);
        run_op("div_neg_neg", 1'b0, 1'b1, -32'sd100, -32'sd7, 32'd14, 1'b0, DivLat);
        run_op("mul_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1,
               MulLat);

        // 6: reset mid-divide discards it
        start_op(1'b0, 1'b1, 32'd1000, 32'd3, e);
        repeat (20) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_result", data_result, 32'd0);
        check("midrst_exc", {31'b0, data_exception}, 32'd0);
        check("midrst_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(posedge clock);
        run_op("mul_5x5", 1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, MulLat);

        repeat (5) @(posedge clock);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
